if_fetch_queue: RTL

Parametrised instruction-fetch stage, successor to the single-entry IF block. Owns the fetch PC and issues held-until-response reads to the I-cache. Buffers fetched {pc, instruction} pairs in a DEPTH-entry FIFO so fetch continues while decode stalls. Handles redirects from EX, including discarding an in-flight response.

---
 rtl/pcmux.sv | 8 +
 rtl/rv32i_types.sv | 4 +
 rtl/fetch_fifo.sv | 40 ++++
 rtl/if_fetch_queue.sv | 108 ++++++++++
 4 files changed

// File: rtl/pcmux.sv
// pcmux: PC mux select encodings shared by fetch and execute
package pcmux;
  typedef enum logic [1:0] {
    pc_plus4 = 2'b00,
    alu_out  = 2'b01,
    alu_mod2 = 2'b10
  } pcmux_sel_t;
endpackage

// File: rtl/rv32i_types.sv
// rv32i_types: shared pipeline types
package rv32i_types;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} ifq_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO with flush; flush overrides push/pop
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wp] <= wdata;
  assign rdata = mem[rp];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetch PC owner, single-outstanding I-cache reads, DEPTH-entry fetch queue.
// IF_BYPASS_EN: present a response combinationally when the queue is empty.
module if_fetch_queue
  import rv32i_types::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h00000060
) (
  input  logic               clk,
  input  logic               rst,
  input  pcmux::pcmux_sel_t  pcmux_sel,
  input  logic [XLEN-1:0]    alu_out,
  output logic               inst_mem_read,
  output logic [XLEN-1:0]    inst_mem_address,
  input  logic [XLEN-1:0]    inst_mem_rdata,
  input  logic               inst_mem_resp,
  output logic               if_out_valid,
  output logic [XLEN-1:0]    if_out_pc,
  output logic [XLEN-1:0]    if_out_instruction,
  input  logic               if_out_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  ifq_state_t state, state_n;
  logic [XLEN-1:0] fetch_pc, fetch_n, req_addr, req_n, target, head_pc, head_inst;
  logic [2*XLEN-1:0] head;
  logic [CW-1:0] count;
  logic redirect, flush, accept, push, pop, full, empty, store, last;
  assign redirect = pcmux_sel == pcmux::alu_out || pcmux_sel == pcmux::alu_mod2;
  assign target = pcmux_sel == pcmux::alu_mod2 ? {alu_out[XLEN-1:1], 1'b0} : alu_out;
  assign inst_mem_read = state == REQ || state == DRAIN;
  assign inst_mem_address = req_addr;
  assign {head_pc, head_inst} = head;
  assign pop = !empty && if_out_ready;
  assign push = accept && store;
  // back-to-back fetch only if the slot this response fills is not the last one
  assign last = store && !pop && count == CW'(DEPTH - 1);
`ifdef IF_BYPASS_EN
  assign store = !(empty && if_out_ready);
  assign if_out_valid = !empty || accept;
  assign if_out_pc = empty ? req_addr : head_pc;
  assign if_out_instruction = empty ? inst_mem_rdata : head_inst;
`else
  assign store = 1'b1;
  assign if_out_valid = !empty;
  assign if_out_pc = head_pc;
  assign if_out_instruction = head_inst;
`endif
  always_comb begin
    state_n = state;
    fetch_n = fetch_pc;
    req_n = req_addr;
    flush = 1'b0;
    accept = 1'b0;
    unique case (state)
      IDLE:
        if (redirect) begin
          fetch_n = target;
          flush = 1'b1;
        end else if (!full) begin
          req_n = fetch_pc;
          state_n = REQ;
        end
      REQ:
        if (inst_mem_resp && redirect) begin
          flush = 1'b1;
          fetch_n = target;
          state_n = IDLE;
        end else if (inst_mem_resp) begin
          accept = 1'b1;
          fetch_n = req_addr + XLEN'(4);
          if (last) state_n = IDLE;
          else req_n = req_addr + XLEN'(4);
        end else if (redirect) begin
          flush = 1'b1;
          fetch_n = target;
          state_n = DRAIN;
        end
      DRAIN: begin
        if (redirect) fetch_n = target;
        if (inst_mem_resp) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state <= state_n;
      fetch_pc <= fetch_n;
      req_addr <= req_n;
    end
  fetch_fifo #(.WIDTH(2 * XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(flush),
    .wdata({req_addr, inst_mem_rdata}),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule
